// File: rtl/seg_score_fmt.sv
// Binary score -> 64-bit active-low seven-segment word (8 digits x 8 bits) via a one-bit-per-clock double-dabble.
// Optional leading-zero blanking is compiled in with `define SEG_BLANK_EN.
// Handshake: load is a one-cycle strobe sampled on every edge (never refused; a load while busy is held one-deep, newest wins); pdata_valid pulses once in the first cycle a new pdata is shown.
module seg_score_fmt #(
  parameter int BIN_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             load,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic [63:0]      pdata,
  output logic             pdata_valid
);

  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    PACK    = 2'd2
  } state_t;

  state_t           state_q;
  logic [BIN_W-1:0] bin_q;
  logic [BIN_W-1:0] pend_val_q;
  logic             pend_q;
  logic [31:0]      bcd_q;
  logic [CW-1:0]    cnt_q;
  logic [63:0]      pdata_q;
  logic             valid_q;

  logic [31:0]      bcd_adj_d;
  logic [63:0]      seg_word_d;

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return ~{1'b0, s};
  endfunction

  always_comb begin
    bcd_adj_d = '0;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                         bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4];
    end
  end

`ifdef SEG_BLANK_EN
  logic lead_zero;
`endif

  always_comb begin
    seg_word_d = '1;
`ifdef SEG_BLANK_EN
    lead_zero = 1'b1;
`endif
    for (int i = 7; i >= 0; i--) begin
      seg_word_d[8*i +: 8] = seg_enc(bcd_q[4*i +: 4]);
`ifdef SEG_BLANK_EN
      // A digit is blanked only if it and every digit above it are zero; digit 0 always shows.
      if (bcd_q[4*i +: 4] != 4'd0) lead_zero = 1'b0;
      if (lead_zero && (i != 0)) seg_word_d[8*i +: 8] = 8'hFF;
`endif
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      pdata_q    <= '1;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (load && (state_q == CONVERT)) begin
        pend_q     <= 1'b1;
        pend_val_q <= value;
      end
      case (state_q)
        IDLE: begin
          if (load) begin
            bin_q   <= value;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_q <= {bcd_adj_d[30:0], bin_q[BIN_W-1]};
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(BIN_W - 1)) state_q <= PACK;
        end
        PACK: begin
          pdata_q <= seg_word_d;
          valid_q <= 1'b1;
          // A load arriving in this very cycle is newer than any held one.
          if (load || pend_q) begin
            bin_q   <= load ? value : pend_val_q;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            state_q <= CONVERT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign pdata       = pdata_q;
  assign pdata_valid = valid_q;

endmodule

// File: tb/tb_seg_score_fmt.sv
// Bench for seg_score_fmt: decimal-arithmetic reference model, expected-word queue and latency checks.
module tb_seg_score_fmt;

  localparam int BIN_W = 16;
  localparam int LAT   = BIN_W + 1;

  logic             clk;
  logic             clrn;
  logic             load;
  logic [BIN_W-1:0] value;
  logic             busy;
  logic [63:0]      pdata;
  logic             pdata_valid;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [63:0] exp_q[$];
  int          exp_t_q[$];
  logic [63:0] last_word = '1;

  seg_score_fmt #(.BIN_W(BIN_W)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .load       (load),
    .value      (value),
    .busy       (busy),
    .pdata      (pdata),
    .pdata_valid(pdata_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model: decimal digits by division, segment table by digit value
  function automatic logic [6:0] seg_hi(input int unsigned d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; default: return 7'h6F;
    endcase
  endfunction

  function automatic logic [63:0] model_word(input int unsigned v);
    logic [63:0] w;
    int unsigned p;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      w[8*i +: 8] = ~{1'b0, seg_hi((v / p) % 10)};
`ifdef SEG_BLANK_EN
      if (i > 0 && v < p) w[8*i +: 8] = 8'hFF;
`endif
      p = p * 10;
    end
    return w;
  endfunction

  // driver tasks
  task automatic do_load(input logic [BIN_W-1:0] v, output int t);
    @(negedge clk);
    load  = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    load = 1'b0;
    t = cyc;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_word(input logic [BIN_W-1:0] v, input int t_done);
    exp_q.push_back(model_word(32'(v)));
    exp_t_q.push_back(t_done);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [63:0] w;
    int          t;
    if (!clrn) last_word = '1;
    if (pdata_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", {63'd0, pdata_valid}, 64'd0);
      end else begin
        w = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check_eq("word", pdata, w);
        check_eq("latency", 64'(cyc), 64'(t));
        last_word = w;
      end
    end else begin
      check_eq("hold", pdata, last_word);
    end
  end

  initial begin
    int t, t2, off;
    logic [BIN_W-1:0] v1, v2;
    clrn  = 1'b0;
    load  = 1'b0;
    value = '0;

    repeat (3) begin
      @(negedge clk);
      check_eq("rst_pdata", pdata, '1);
      check_eq("rst_busy", {63'd0, busy}, 64'd0);
      check_eq("rst_valid", {63'd0, pdata_valid}, 64'd0);
    end
    @(posedge clk);
    #1 clrn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_busy", {63'd0, busy}, 64'd0);
    end

    // directed values
    do_load(BIN_W'(0), t);
    expect_word(BIN_W'(0), t + LAT);
    @(negedge clk);
    check_eq("busy_rise", {63'd0, busy}, 64'd1);
    drain();
    @(negedge clk);
    check_eq("busy_fall", {63'd0, busy}, 64'd0);

    do_load(BIN_W'(12345), t);
    expect_word(BIN_W'(12345), t + LAT);
    drain();
    do_load(BIN_W'(65535), t);
    expect_word(BIN_W'(65535), t + LAT);
    drain();

    // random isolated loads
    for (int k = 0; k < 20; k++) begin
      v1 = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
      if (k % 5 == 0) v1 = BIN_W'($urandom_range(0, 99));
      do_load(v1, t);
      expect_word(v1, t + LAT);
      drain();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // A/B/C: B is overwritten by C while A converts
    do_load(BIN_W'(1), t);
    expect_word(BIN_W'(1), t + LAT);
    wait_until(t + 4);
    do_load(BIN_W'(2), t2);
    wait_until(t + 8);
    do_load(BIN_W'(3), t2);
    expect_word(BIN_W'(3), t + 2 * LAT);
    while (cyc < t + 2 * LAT) begin
      check_eq("busy_pend", {63'd0, busy}, 64'd1);
      @(negedge clk);
    end
    check_eq("busy_after_c", {63'd0, busy}, 64'd0);
    drain();

    // random second load: queued if it arrives by the result edge, else fresh start
    for (int k = 0; k < 12; k++) begin
      v1  = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
      v2  = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
      off = (k == 0) ? LAT : (k == 1) ? LAT + 1 : $urandom_range(1, LAT + 3);
      do_load(v1, t);
      expect_word(v1, t + LAT);
      wait_until(t + off - 1);
      do_load(v2, t2);
      expect_word(v2, (off <= LAT) ? t + 2 * LAT : t + off + LAT);
      drain();
      @(posedge clk);
      #1;
    end

    // reset mid-conversion aborts without a result
    do_load(BIN_W'(12345), t);
    wait_until(t + 8);
    clrn = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("abort_pdata", pdata, '1);
      check_eq("abort_busy", {63'd0, busy}, 64'd0);
    end
    @(posedge clk);
    #1 clrn = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    check_eq("abort_idle", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    do_load(BIN_W'(7), t);
    expect_word(BIN_W'(7), t + LAT);
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_score_fmt.md
# seg_score_fmt

Converts a binary score into the 64-bit seven-segment pattern word that feeds the display shift-register serializer's `pdata` input. Loads are sampled on a strobe, then converted to BCD by a sequential double-dabble engine (one bit per clock). Each digit is encoded to active-low segments, and the word is packed as 8 digits × 8 bits. The output is held stable between updates, so the serializer can sample it at any frame boundary.

## Interface
- `BIN_W`, 16, binary score width; legal range 4..26.
- `clk`  input  1  system clock; all state updates on rising edge.
- `clrn`  input  1  asynchronous active-low reset.
- `load`  input  1  single-cycle strobe; sample `value` on this edge.
- `value`  input  BIN_W  unsigned score.
- `busy`  output  1  high while a conversion is in progress.
- `pdata`  output  64  segment word to serializer; digit i at bits [8i+7:8i], bit order {dp,g,f,e,c... } = {dp,g,f,e,d,c,b,a} at bits 7..0; active-low (0 = segment lit).
- `pdata_valid`  output  1  one-cycle pulse in the cycle `pdata` first shows a new word.

## Operation
- States:
  - IDLE: no conversion running.
  - CONVERT: double-dabble in progress.
  - PACK: segment encoding and output update.
- IDLE + `load`:
  - Capture `value` into the shift register and zero the BCD register (32 bits, 8 nibbles).
  - Clear the bit counter and go to CONVERT.
- CONVERT, one bit per clock:
  - Add 3 to every BCD nibble ≥5.
  - Shift {bcd, bin} left by 1.
  - After BIN_W shifts, go to PACK.
- PACK:
  - Encode each nibble through the active-high table 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F, then invert.
  - dp is always off (bit 7 = 1).
  - Register into `pdata` and pulse `pdata_valid`.
  - Then go to IDLE, or directly to CONVERT if a load is pending.
- Leading-zero blanking (see Configuration):
  - Digits above the most-significant nonzero digit output 0xFF.
  - Digit 0 is always displayed, so value 0 shows "0".
- Pending load:
  - One-deep pending register, set by `load` while state ≠ IDLE.
  - A later load overwrites the stored value (newest wins).
  - The pending load is consumed at the PACK→CONVERT transition.
- `load` in the same cycle as PACK is treated as pending and starts at that same edge.
- `pdata` changes only in PACK; it is never partially updated.
- Reset values:
  - State IDLE.
  - `busy` = 0, `pdata_valid` = 0.
  - `pdata` = 64'hFFFF_FFFF_FFFF_FFFF (all blank).
  - Pending flag and BCD register cleared.
- Reset mid-conversion aborts the conversion; no `pdata_valid` is emitted for the aborted load.

## Timing
- `load` sampled at edge E0.
- Shifts occur at edges E1..E_BIN_W.
- `pdata` and `pdata_valid` are registered at edge E_(BIN_W+1).
- Latency is BIN_W+1 clocks (17 with default BIN_W=16).
- `busy` rises at E0 and falls at E_(BIN_W+1) when no load is pending.
- With a pending load, `busy` stays high continuously.
- Back-to-back throughput is one result per BIN_W+1 clocks.
- `pdata_valid` is high for exactly one cycle per completed conversion.

## Configuration
- `SEG_BLANK_EN` defined: leading-zero blanking as described.
- `SEG_BLANK_EN` undefined: all 8 digits are always encoded, leading zeros show "0" (0xC0), and the blanking logic is not synthesized.

## Test plan
- Reset: hold `clrn`=0 for 3 clocks, then release.
  - Required: `pdata`=FFFF_FFFF_FFFF_FFFF, `busy`=0, `pdata_valid`=0 until the first load.
- `value`=0 (BLANK_EN):
  - Required: 17 clocks after the load edge, `pdata`=FFFF_FFFF_FFFF_FFC0 with a 1-cycle `pdata_valid`.
- `value`=12345:
  - With BLANK_EN: `pdata`=FFFF_FFF9_A4B0_9992.
  - Without BLANK_EN: `pdata`=C0C0_C0F9_A4B0_9992.
- `value`=65535 (BLANK_EN):
  - Required: `pdata`=FFFF_FF82_9292_B092.
- Loads A=1, B=2, C=3 on cycles 0, 5, 9:
  - Required: exactly two `pdata_valid` pulses, for A then C.
  - C's word appears 17 clocks after A's.
  - `busy` stays high in between.
- Load 12345, then assert `clrn`=0 at clock 8:
  - Required: `pdata` returns to all-FF, no `pdata_valid` pulse, `busy`=0.
  - A fresh load of 7 then yields FFFF_FFFF_FFFF_FFF8.
